rr_mux_sel: RTL and testbench

Parametrised N-channel, WIDTH-bit selector with valid/ready handshakes on every input and on the output, and a one-beat registered output stage. Generalises the 3:1 single-bit combinational selector. Two modes:
- fixed-select: software-driven `sel`
- round-robin: fair arbitration across valid channels

Sits between multiple producers and a single downstream consumer in the datapath.

---
 rtl/rr_mux_sel_pkg.sv | 18 +
 rtl/rr_mux_sel_if.sv | 30 +++
 rtl/rr_mux_sel_arbiter.sv | 52 +++++
 rtl/rr_mux_sel.sv | 88 ++++++++
 tb/tb_rr_mux_sel.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/rr_mux_sel_pkg.sv
// Shared definitions for the round-robin / fixed-select channel selector.
// Mode encodings and the select-width helper used by every block of the slice.
package rr_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Width needed to index n channels, never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_mux_sel_if.sv
// Producer/consumer bundle of the selector: per-channel valid/ready/data in,
// one registered valid/ready/data/channel-index out.
interface rr_mux_sel_if
    import rr_mux_pkg::*;
#(
    parameter int N_CH  = 3,
    parameter int WIDTH = 1
) ();

    localparam int SEL_W = clog2_min1(N_CH);

    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_ch;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

endinterface

// File: rtl/rr_mux_sel_arbiter.sv
// Combinational round-robin arbiter: first requester strictly after ptr wins,
// found by rotating a doubled request vector and priority-encoding it.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int N_CH  = 3,
    parameter int SEL_W = clog2_min1(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  grant
);

    typedef logic [SEL_W:0] idx_t;

    localparam idx_t LAST = idx_t'(N_CH - 1);
    localparam idx_t NCH  = idx_t'(N_CH);

    logic [2*N_CH-1:0] w_dbl;
    logic [N_CH-1:0]   w_rot;
    idx_t              w_start;
    idx_t              w_off;
    idx_t              w_idx;
    logic              w_found;

    // Offsets are counted from ptr+1; the winner index is folded back modulo N_CH.
    always_comb begin
        w_start = ({1'b0, ptr} >= LAST) ? '0 : ({1'b0, ptr} + idx_t'(1));
        w_dbl   = {req, req};
        w_rot   = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_rot[i] = w_dbl[w_start + idx_t'(i)];
        end
        w_found = 1'b0;
        w_off   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_found = 1'b1;
                w_off   = idx_t'(i);
            end
        end
        w_idx = w_start + w_off;
        if (w_idx >= NCH) begin
            w_idx = w_idx - NCH;
        end
        grant = '0;
        for (int i = 0; i < N_CH; i++) begin
            grant[i] = w_found && (w_idx == idx_t'(i));
        end
    end

endmodule

// File: rtl/rr_mux_sel.sv
// N-channel selector with fixed-select or round-robin grant and a one-beat
// registered output stage with valid/ready backpressure.
module rr_mux_sel
    import rr_mux_pkg::*;
#(
    parameter int N_CH  = 3,
    parameter int WIDTH = 1,
    parameter int SEL_W = clog2_min1(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    rr_mux_sel_if.slave      bus
);

    typedef logic [SEL_W-1:0] sel_t;

    logic [WIDTH-1:0] r_out_data;
    sel_t             r_out_ch;
    logic             r_out_valid;
    sel_t             r_ptr;

    logic             w_load_en;
    logic [N_CH-1:0]  w_sel_grant;
    logic [N_CH-1:0]  w_arb_grant;
    logic [N_CH-1:0]  w_grant;
    logic [N_CH-1:0]  w_ready;
    logic             w_xfer;
    sel_t             w_xfer_ch;
    logic [WIDTH-1:0] w_xfer_data;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req   (bus.in_valid),
        .ptr   (r_ptr),
        .grant (w_arb_grant)
    );

    // An out-of-range sel matches no channel, so it simply never grants.
    always_comb begin
        w_load_en   = ~r_out_valid | bus.out_ready;
        w_sel_grant = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_sel_grant[i] = (sel == sel_t'(i)) & bus.in_valid[i];
        end
        w_grant     = (mode == MODE_RR) ? w_arb_grant : w_sel_grant;
        w_ready     = w_grant & {N_CH{w_load_en}};
        w_xfer      = |(w_ready & bus.in_valid);
        w_xfer_ch   = '0;
        w_xfer_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_grant[i]) begin
                w_xfer_ch   = sel_t'(i);
                w_xfer_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Reset leaves ptr on the last channel so the first round-robin winner is ch0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= sel_t'(N_CH - 1);
        end else if (w_load_en) begin
            if (w_xfer) begin
                r_out_data  <= w_xfer_data;
                r_out_ch    <= w_xfer_ch;
                r_out_valid <= 1'b1;
                if (mode == MODE_RR) begin
                    r_ptr <= w_xfer_ch;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_mux_sel.sv
// Directed table-driven bench for rr_mux_sel: a 3x1 instance for fixed-select
// and a 4x8 instance for round-robin, backpressure and asynchronous reset.
module tb_rr_mux_sel;

    typedef struct {
        logic        which;
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        oready;
        logic [3:0]  expReady;
        logic        expValid;
        logic [7:0]  expData;
        logic [1:0]  expCh;
    } vec_t;

    logic       clk;
    logic       rstN;
    logic       mode3;
    logic [1:0] sel3;
    logic       mode4;
    logic [1:0] sel4;
    int         total;
    int         bad;
    vec_t       tbl[30];

    rr_mux_sel_if #(.N_CH(3), .WIDTH(1)) bus3 ();
    rr_mux_sel_if #(.N_CH(4), .WIDTH(8)) bus4 ();

    rr_mux_sel #(.N_CH(3), .WIDTH(1)) dut3 (
        .clk   (clk),
        .rst_n (rstN),
        .mode  (mode3),
        .sel   (sel3),
        .bus   (bus3.slave)
    );

    rr_mux_sel #(.N_CH(4), .WIDTH(8)) dut4 (
        .clk   (clk),
        .rst_n (rstN),
        .mode  (mode4),
        .sel   (sel4),
        .bus   (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(int which, int mode, int sel, int valid, int data, int oready,
                                int er, int ev, int ed, int ech);
        vec_t v;
        v.which    = 1'(which);
        v.mode     = 1'(mode);
        v.sel      = 2'(sel);
        v.valid    = 4'(valid);
        v.data     = 32'(data);
        v.oready   = 1'(oready);
        v.expReady = 4'(er);
        v.expValid = 1'(ev);
        v.expData  = 8'(ed);
        v.expCh    = 2'(ech);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.which == 1'b0) begin
            mode3          = v.mode;
            sel3           = v.sel;
            bus3.in_valid  = v.valid[2:0];
            bus3.in_data   = v.data[2:0];
            bus3.out_ready = v.oready;
        end else begin
            mode4          = v.mode;
            sel4           = v.sel;
            bus4.in_valid  = v.valid;
            bus4.in_data   = v.data;
            bus4.out_ready = v.oready;
        end
    endtask

    task automatic checkRow(input int idx, input vec_t v);
        if (v.which == 1'b0) begin
            checkOutput($sformatf("row%0d in_ready", idx), 32'(bus3.in_ready), 32'(v.expReady[2:0]));
        end else begin
            checkOutput($sformatf("row%0d in_ready", idx), 32'(bus4.in_ready), 32'(v.expReady));
        end
        @(posedge clk);
        #1;
        if (v.which == 1'b0) begin
            checkOutput($sformatf("row%0d out_valid", idx), 32'(bus3.out_valid), 32'(v.expValid));
            checkOutput($sformatf("row%0d out_data", idx), 32'(bus3.out_data), 32'(v.expData[0]));
            checkOutput($sformatf("row%0d out_ch", idx), 32'(bus3.out_ch), 32'(v.expCh));
        end else begin
            checkOutput($sformatf("row%0d out_valid", idx), 32'(bus4.out_valid), 32'(v.expValid));
            checkOutput($sformatf("row%0d out_data", idx), 32'(bus4.out_data), 32'(v.expData));
            checkOutput($sformatf("row%0d out_ch", idx), 32'(bus4.out_ch), 32'(v.expCh));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // 3x1 fixed-select; rows 7..11 show fixed transfers never move ptr
        tbl[0]  = mk(0, 0, 0, 7, 6, 1, 1, 1, 0, 0);
        tbl[1]  = mk(0, 0, 1, 7, 6, 1, 2, 1, 1, 1);
        tbl[2]  = mk(0, 0, 2, 7, 6, 1, 4, 1, 1, 2);
        tbl[3]  = mk(0, 0, 3, 7, 6, 1, 0, 0, 1, 2);
        tbl[4]  = mk(0, 0, 3, 7, 6, 1, 0, 0, 1, 2);
        tbl[5]  = mk(0, 0, 1, 5, 6, 1, 0, 0, 1, 2);
        tbl[6]  = mk(0, 0, 0, 5, 6, 1, 1, 1, 0, 0);
        tbl[7]  = mk(0, 1, 0, 7, 6, 1, 1, 1, 0, 0);
        tbl[8]  = mk(0, 1, 0, 7, 6, 1, 2, 1, 1, 1);
        tbl[9]  = mk(0, 0, 2, 7, 6, 0, 0, 1, 1, 1);
        tbl[10] = mk(0, 0, 2, 7, 6, 1, 4, 1, 1, 2);
        tbl[11] = mk(0, 1, 0, 7, 6, 1, 4, 1, 1, 2);
        // 4x8 round-robin
        tbl[12] = mk(1, 1, 0, 15, 32'h44332211, 1, 1, 1, 8'h11, 0);
        tbl[13] = mk(1, 1, 0, 15, 32'h44332211, 1, 2, 1, 8'h22, 1);
        tbl[14] = mk(1, 1, 0, 15, 32'h44332211, 1, 4, 1, 8'h33, 2);
        tbl[15] = mk(1, 1, 0, 15, 32'h44332211, 1, 8, 1, 8'h44, 3);
        tbl[16] = mk(1, 1, 0, 15, 32'h44332211, 1, 1, 1, 8'h11, 0);
        tbl[17] = mk(1, 1, 0, 10, 32'h44332211, 1, 2, 1, 8'h22, 1);
        tbl[18] = mk(1, 1, 0, 10, 32'h44332211, 1, 8, 1, 8'h44, 3);
        tbl[19] = mk(1, 1, 0, 10, 32'h44332211, 1, 2, 1, 8'h22, 1);
        tbl[20] = mk(1, 1, 0, 10, 32'h44332211, 1, 8, 1, 8'h44, 3);
        tbl[21] = mk(1, 1, 0, 2, 32'h44332211, 1, 2, 1, 8'h22, 1);
        tbl[22] = mk(1, 1, 0, 2, 32'h44332211, 1, 2, 1, 8'h22, 1);
        tbl[23] = mk(1, 1, 0, 2, 32'h44332211, 1, 2, 1, 8'h22, 1);
        tbl[24] = mk(1, 1, 0, 0, 32'h44332211, 1, 0, 0, 8'h22, 1);
        // beat from ch2 held under backpressure, then ch3 wins
        tbl[25] = mk(1, 1, 0, 15, 32'h44332211, 1, 4, 1, 8'h33, 2);
        tbl[26] = mk(1, 1, 0, 15, 32'h44332211, 0, 0, 1, 8'h33, 2);
        tbl[27] = mk(1, 1, 0, 15, 32'h44332211, 0, 0, 1, 8'h33, 2);
        tbl[28] = mk(1, 1, 0, 15, 32'h44332211, 0, 0, 1, 8'h33, 2);
        tbl[29] = mk(1, 1, 0, 15, 32'h44332211, 1, 8, 1, 8'h44, 3);

        rstN           = 1'b0;
        mode3          = 1'b0;
        sel3           = 2'd0;
        mode4          = 1'b1;
        sel4           = 2'd0;
        bus3.in_valid  = '0;
        bus3.in_data   = '0;
        bus3.out_ready = 1'b1;
        bus4.in_valid  = '0;
        bus4.in_data   = '0;
        bus4.out_ready = 1'b1;

        #12;
        checkOutput("reset3 out_valid", 32'(bus3.out_valid), 32'd0);
        checkOutput("reset3 out_data", 32'(bus3.out_data), 32'd0);
        checkOutput("reset3 out_ch", 32'(bus3.out_ch), 32'd0);
        checkOutput("reset4 out_valid", 32'(bus4.out_valid), 32'd0);
        checkOutput("reset4 out_data", 32'(bus4.out_data), 32'd0);
        checkOutput("reset4 out_ch", 32'(bus4.out_ch), 32'd0);
        @(negedge clk);
        rstN = 1'b1;

        for (int i = 0; i < 30; i++) begin
            applyStimulus(tbl[i]);
            #1;
            checkRow(i, tbl[i]);
        end

        // asynchronous reset while dut4 holds a valid beat from ch3
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("midreset out_valid", 32'(bus4.out_valid), 32'd0);
        checkOutput("midreset out_data", 32'(bus4.out_data), 32'd0);
        checkOutput("midreset out_ch", 32'(bus4.out_ch), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checkOutput("postreset in_ready", 32'(bus4.in_ready), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("postreset out_valid", 32'(bus4.out_valid), 32'd1);
        checkOutput("postreset out_data", 32'(bus4.out_data), 32'h11);
        checkOutput("postreset out_ch", 32'(bus4.out_ch), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
